// File: rtl/mul_op_issue.sv
// Issue controller in front of the 33-bit Booth/Wallace multiplier core: one op in flight, watchdog on WAIT.
// Optional: define MUL_ZERO_BYPASS_EN to answer zero-operand requests without using the core.
module mul_op_issue #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [XLEN-1:0]   req_src1,
   input  logic [XLEN-1:0]   req_src2,
   output logic              mul_in_valid,
   input  logic              mul_in_ready,
   output logic [XLEN:0]     mul_src1,
   output logic [XLEN:0]     mul_src2,
   input  logic              mul_out_valid,
   input  logic [2*XLEN-1:0] mul_result,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_data,
   output logic              resp_err,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready; once valid is
   // raised it and its payload stay unchanged until that transfer completes.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t            r_state;
   logic [1:0]        r_op;
   logic [XLEN:0]     r_mul_src1;
   logic [XLEN:0]     r_mul_src2;
   logic              r_mul_in_valid;
   logic              r_resp_valid;
   logic [XLEN-1:0]   r_resp_data;
   logic              r_resp_err;
   logic [CW-1:0]     r_cnt;

   logic              w_src1_signed;
   logic              w_src2_signed;
   logic [XLEN:0]     w_ext1;
   logic [XLEN:0]     w_ext2;

   // MULHU treats src1 as unsigned; MULHSU and MULHU treat src2 as unsigned.
   assign w_src1_signed = (req_op != 2'b11);
   assign w_src2_signed = (req_op[1] == 1'b0);
   assign w_ext1 = {w_src1_signed & req_src1[XLEN-1], req_src1};
   assign w_ext2 = {w_src2_signed & req_src2[XLEN-1], req_src2};

`ifdef MUL_ZERO_BYPASS_EN
   logic w_new_zero;
   logic w_lat_zero;
   assign w_new_zero = (req_src1 == '0) || (req_src2 == '0);
   assign w_lat_zero = (r_mul_src1 == '0) || (r_mul_src2 == '0);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_op           <= 2'b00;
         r_mul_src1     <= '0;
         r_mul_src2     <= '0;
         r_mul_in_valid <= 1'b0;
         r_resp_valid   <= 1'b0;
         r_resp_data    <= '0;
         r_resp_err     <= 1'b0;
         r_cnt          <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_op       <= req_op;
                  r_mul_src1 <= w_ext1;
                  r_mul_src2 <= w_ext2;
`ifdef MUL_ZERO_BYPASS_EN
                  r_mul_in_valid <= !w_new_zero;
`else
                  r_mul_in_valid <= 1'b1;
`endif
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
`ifdef MUL_ZERO_BYPASS_EN
               if (w_lat_zero) begin
                  r_resp_data  <= '0;
                  r_resp_err   <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else
`endif
               if (mul_in_ready) begin
                  r_mul_in_valid <= 1'b0;
                  r_cnt          <= '0;
                  r_state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A result pulse in the last watchdog cycle still counts as a good answer.
               if (mul_out_valid) begin
                  r_resp_data  <= (r_op == 2'b00) ? mul_result[XLEN-1:0]
                                                  : mul_result[2*XLEN-1:XLEN];
                  r_resp_err   <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (r_cnt == CNT_LAST) begin
                  r_resp_data  <= '0;
                  r_resp_err   <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Gated with reset so the block never looks ready while reset is being held.
   assign req_ready    = (r_state == S_IDLE) && reset;
   assign mul_in_valid = r_mul_in_valid;
   assign mul_src1     = r_mul_src1;
   assign mul_src2     = r_mul_src2;
   assign resp_valid   = r_resp_valid;
   assign resp_data    = r_resp_data;
   assign resp_err     = r_resp_err;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_mul_op_issue.sv
// Bench for mul_op_issue: behavioural multiplier core, randomized requests, arithmetic reference model.
// Build with MUL_ZERO_BYPASS_EN defined to cover the zero-operand shortcut.
module tb_mul_op_issue;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 15;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [XLEN-1:0]   req_src1;
   logic [XLEN-1:0]   req_src2;
   logic              mul_in_valid;
   logic              mul_in_ready;
   logic [XLEN:0]     mul_src1;
   logic [XLEN:0]     mul_src2;
   logic              mul_out_valid;
   logic [2*XLEN-1:0] mul_result;
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_data;
   logic              resp_err;
   logic [1:0]        dbg_state;

   mul_op_issue #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2),
      .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready),
      .mul_src1(mul_src1), .mul_src2(mul_src2),
      .mul_out_valid(mul_out_valid), .mul_result(mul_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "tb watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [XLEN:0] exp_q[$];   // {err, data}

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: extend to 64 bits by the op's signedness, multiply mod 2^64, pick the half.
   function automatic logic [63:0] ext64(input logic [31:0] v, input bit is_signed);
      return is_signed ? {{32{v[31]}}, v} : {32'h0, v};
   endfunction

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = ext64(a, op != 2'b11) * ext64(b, op == 2'b00 || op == 2'b01);
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // ---------------- behavioural multiplier core ----------------
   int  core_stall  = 0;
   bit  core_silent = 0;
   bit  stray_tgl   = 0;

   initial begin : core_model
      int pend_due;
      int stall_cnt;
      bit prev_miv;
      bit stray_seen;
      logic [63:0] pend_prod;
      logic signed [32:0] ca, cb;
      logic signed [65:0] cp;
      pend_due = 0; stall_cnt = 0; prev_miv = 0; stray_seen = 0; pend_prod = '0;
      mul_in_ready = 1'b0; mul_out_valid = 1'b0; mul_result = '0;
      forever begin
         @(posedge clk); #1;
         mul_out_valid = 1'b0;
         mul_result = {$urandom, $urandom};
         if (pend_due > 0) begin
            pend_due--;
            if (pend_due == 0) begin
               mul_out_valid = 1'b1;
               mul_result = pend_prod;
            end
         end
         if (stray_tgl != stray_seen) begin
            stray_seen = stray_tgl;
            mul_out_valid = 1'b1;
         end
         if (mul_in_valid === 1'b1 && !prev_miv) stall_cnt = core_stall;
         prev_miv = (mul_in_valid === 1'b1);
         if (mul_in_valid === 1'b1) begin
            if (stall_cnt > 0) begin
               mul_in_ready = 1'b0;
               stall_cnt--;
            end else begin
               mul_in_ready = 1'b1;
            end
         end else begin
            mul_in_ready = 1'($urandom_range(0, 1));
         end
         if (mul_in_valid === 1'b1 && mul_in_ready && !core_silent) begin
            ca = mul_src1; cb = mul_src2;
            cp = ca * cb;
            pend_prod = cp[63:0];
            pend_due = 2;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_op(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input int stall, input int hold, input bit silent, output logic [31:0] got);
      int k, miv_n, exp_lat, exp_miv;
      bit bypass;
      logic [XLEN:0] exp;
      logic [63:0] e1, e2;
      core_stall = stall;
      core_silent = silent;
      e1 = ext64(s1, op != 2'b11);
      e2 = ext64(s2, op == 2'b00 || op == 2'b01);
`ifdef MUL_ZERO_BYPASS_EN
      bypass = (s1 == 0) || (s2 == 0);
`else
      bypass = 0;
`endif
      if (bypass) begin
         exp = '0; exp_lat = 2; exp_miv = 0;
      end else if (silent) begin
         exp = {1'b1, 32'h0}; exp_lat = 2 + stall + TIMEOUT; exp_miv = 1 + stall;
      end else begin
         exp = {1'b0, ref_mul(op, s1, s2)}; exp_lat = 4 + stall; exp_miv = 1 + stall;
      end
      exp_q.push_back(exp);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready_idle", req_ready, 1);
      k = 0; miv_n = 0;
      do begin
         @(negedge clk);
         req_valid = 1'b0;
         req_src1 = $urandom; req_src2 = $urandom;
         k++;
         if (mul_in_valid) miv_n++;
      end while (!resp_valid && k < 60);
      chk("resp_latency", k, exp_lat);
      chk("mul_in_valid_cycles", miv_n, exp_miv);
      chk("mul_src1", mul_src1, e1[32:0]);
      chk("mul_src2", mul_src2, e2[32:0]);
      exp = exp_q.pop_front();
      chk("resp_data", resp_data, exp[31:0]);
      chk("resp_err", resp_err, exp[32]);
      got = resp_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", resp_valid, 1);
         chk("hold_payload", {resp_err, resp_data}, exp);
         chk("hold_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("post_resp_valid", resp_valid, 0);
      chk("post_req_ready", req_ready, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_mul_in_valid"}, mul_in_valid, 0);
      chk({tag, "_mul_src1"}, mul_src1, 0);
      chk({tag, "_mul_src2"}, mul_src2, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_resp_err"}, resp_err, 0);
      chk({tag, "_dbg_state"}, dbg_state, 0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin : main
      logic [31:0] got;
      reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      reset = 1'b1;
      @(negedge clk);
      chk("rst_release_req_ready", req_ready, 1);

      // Directed operations with known results
      do_op(2'b00, 32'hFFFF_FFFF, 32'h3, 0, 0, 0, got);
      chk("tp_mul", got, 32'hFFFF_FFFD);
      do_op(2'b01, 32'hFFFF_FFFF, 32'h3, 0, 0, 0, got);
      chk("tp_mulh", got, 32'hFFFF_FFFF);
      do_op(2'b11, 32'hFFFF_FFFF, 32'h3, 0, 0, 0, got);
      chk("tp_mulhu", got, 32'h2);
      do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6, 0, got);
      chk("tp_mulhsu", got, 32'hFFFF_FFFF);
      do_op(2'b00, 32'd1234, 32'd5678, 10, 0, 0, got);
      chk("tp_stall", got, 32'd7006652);

      // Core never answers, then a stray pulse arrives while idle
      do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, 2, 1, got);
      stray_tgl = ~stray_tgl;
      repeat (2) begin
         @(negedge clk);
         chk("stray_resp_valid", resp_valid, 0);
         chk("stray_mul_in_valid", mul_in_valid, 0);
         chk("stray_req_ready", req_ready, 1);
      end
      core_silent = 0;

      // Zero operand (shortcut when the bypass is built in)
      do_op(2'b11, 32'h0, 32'h5, 0, 0, 0, got);
      chk("tp_zero", got, 32'h0);

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
               $urandom_range(0, 3), $urandom_range(0, 3), 0, got);
      end

      // Reset in WAIT: previous response leaves nonzero data behind
      do_op(2'b00, 32'd5, 32'd5, 0, 0, 0, got);
      core_stall = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd9;
      @(negedge clk);                 // cycle 1: ISSUE
      req_valid = 1'b0;
      @(negedge clk);                 // cycle 2: WAIT
      reset = 1'b0;
      @(negedge clk);                 // cycle 3: reset applied, core pulse arrives now
      chk_reset_outputs("midrst");
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_mul_in_valid", mul_in_valid, 0);
      do_op(2'b00, 32'd7, 32'd6, 0, 0, 0, got);
      chk("tp_after_reset", got, 32'd42);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
